// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the execute-issue stage: ALU operation codes,
// major opcodes and funct3/funct7 encodings used by the decoder.
package rv32i_pkg;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'b0000,
    ALU_SUB    = 4'b0001,
    ALU_SLL    = 4'b0010,
    ALU_SLT    = 4'b0011,
    ALU_SLTU   = 4'b0100,
    ALU_XOR    = 4'b0101,
    ALU_SRL    = 4'b0110,
    ALU_SRA    = 4'b0111,
    ALU_OR     = 4'b1000,
    ALU_AND    = 4'b1001,
    ALU_PASS_B = 4'b1111
  } alu_op_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/alu_issue_if.sv
// ALU operand/control bus. Handshake: a transfer happens on a rising edge where
// out_valid && out_ready; while out_valid && !out_ready the producer holds every field stable.
interface alu_issue_if #(
  parameter int DataWidth    = 32,
  parameter int RegAddrWidth = 5
);
  logic                    out_valid;
  logic                    out_ready;
  logic [DataWidth-1:0]    operand_a;
  logic [DataWidth-1:0]    operand_b;
  logic [3:0]              alu_control;
  logic [RegAddrWidth-1:0] rd_addr;
  logic                    reg_write;
  logic                    illegal;

  modport master (
    output out_valid, operand_a, operand_b, alu_control, rd_addr, reg_write, illegal,
    input  out_ready
  );

  modport slave (
    input  out_valid, operand_a, operand_b, alu_control, rd_addr, reg_write, illegal,
    output out_ready
  );
endinterface

// File: rtl/alu_decode.sv
// Combinational decode of ALU-class RV32I instructions into operands and control.
// Any illegal or malformed encoding yields zero operands, ADD control and no writeback.
module alu_decode
  import rv32i_pkg::*;
#(
  parameter int DataWidth    = 32,
  parameter int RegAddrWidth = 5
) (
  input  logic [31:0]             instr,
  input  logic [DataWidth-1:0]    pc,
  input  logic [DataWidth-1:0]    rs1_data,
  input  logic [DataWidth-1:0]    rs2_data,
  output logic [DataWidth-1:0]    operand_a,
  output logic [DataWidth-1:0]    operand_b,
  output alu_op_e                 alu_control,
  output logic [RegAddrWidth-1:0] rd_addr,
  output logic                    reg_write,
  output logic                    illegal
);

  logic [6:0]           opcode;
  logic [2:0]           funct3;
  logic [6:0]           funct7;
  logic [DataWidth-1:0] imm_i;
  logic [DataWidth-1:0] imm_u;
  logic [DataWidth-1:0] shamt_imm;
  logic [DataWidth-1:0] shamt_reg;

  assign opcode    = instr[6:0];
  assign funct3    = instr[14:12];
  assign funct7    = instr[31:25];
  assign rd_addr   = instr[11:7];
  assign imm_i     = {{20{instr[31]}}, instr[31:20]};
  assign imm_u     = {instr[31:12], 12'b0};
  assign shamt_imm = {27'b0, instr[24:20]};
  assign shamt_reg = {27'b0, rs2_data[4:0]};

  always_comb begin
    operand_a   = '0;
    operand_b   = '0;
    alu_control = ALU_ADD;
    illegal     = 1'b0;
    case (opcode)
      OPC_OP: begin
        operand_a = rs1_data;
        operand_b = rs2_data;
        // funct7 ALT is only meaningful for sub and sra
        if (funct7 != F7_BASE &&
            !(funct7 == F7_ALT && (funct3 == F3_ADD_SUB || funct3 == F3_SRL_SRA))) begin
          illegal = 1'b1;
        end
        case (funct3)
          F3_ADD_SUB: alu_control = (funct7 == F7_ALT) ? ALU_SUB : ALU_ADD;
          F3_SLL: begin
            alu_control = ALU_SLL;
            operand_b   = shamt_reg;
          end
          F3_SLT:     alu_control = ALU_SLT;
          F3_SLTU:    alu_control = ALU_SLTU;
          F3_XOR:     alu_control = ALU_XOR;
          F3_SRL_SRA: begin
            alu_control = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            operand_b   = shamt_reg;
          end
          F3_OR:      alu_control = ALU_OR;
          default:    alu_control = ALU_AND;
        endcase
      end
      OPC_OP_IMM: begin
        operand_a = rs1_data;
        operand_b = imm_i;
        case (funct3)
          F3_ADD_SUB: alu_control = ALU_ADD;
          F3_SLL: begin
            alu_control = ALU_SLL;
            operand_b   = shamt_imm;
            illegal     = (funct7 != F7_BASE);
          end
          F3_SLT:     alu_control = ALU_SLT;
          F3_SLTU:    alu_control = ALU_SLTU;
          F3_XOR:     alu_control = ALU_XOR;
          F3_SRL_SRA: begin
            alu_control = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            operand_b   = shamt_imm;
            illegal     = (funct7 != F7_BASE) && (funct7 != F7_ALT);
          end
          F3_OR:      alu_control = ALU_OR;
          default:    alu_control = ALU_AND;
        endcase
      end
      OPC_LUI: begin
        operand_b   = imm_u;
        alu_control = ALU_PASS_B;
      end
      OPC_AUIPC: begin
        operand_a = pc;
        operand_b = imm_u;
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) begin
      operand_a   = '0;
      operand_b   = '0;
      alu_control = ALU_ADD;
    end
  end

  assign reg_write = !illegal && (rd_addr != '0);

endmodule

// File: rtl/alu_issue.sv
// Execute-issue stage: one pipeline register between the register-file read and the ALU,
// with valid/ready backpressure and flush. Decode lives in alu_decode.
module alu_issue
  import rv32i_pkg::*;
#(
  parameter int DataWidth    = 32,
  parameter int RegAddrWidth = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          instr,
  input  logic [DataWidth-1:0] pc,
  input  logic [DataWidth-1:0] rs1_data,
  input  logic [DataWidth-1:0] rs2_data,
  alu_issue_if.master          alu_if
);

  logic [DataWidth-1:0]    dec_a;
  logic [DataWidth-1:0]    dec_b;
  alu_op_e                 dec_ctrl;
  logic [RegAddrWidth-1:0] dec_rd;
  logic                    dec_rw;
  logic                    dec_ill;

  alu_decode #(
    .DataWidth   (DataWidth),
    .RegAddrWidth(RegAddrWidth)
  ) u_decode (
    .instr      (instr),
    .pc         (pc),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .operand_a  (dec_a),
    .operand_b  (dec_b),
    .alu_control(dec_ctrl),
    .rd_addr    (dec_rd),
    .reg_write  (dec_rw),
    .illegal    (dec_ill)
  );

  logic                    out_valid_q,   out_valid_d;
  logic [DataWidth-1:0]    operand_a_q,   operand_a_d;
  logic [DataWidth-1:0]    operand_b_q,   operand_b_d;
  logic [3:0]              alu_control_q, alu_control_d;
  logic [RegAddrWidth-1:0] rd_addr_q,     rd_addr_d;
  logic                    reg_write_q,   reg_write_d;
  logic                    illegal_q,     illegal_d;
  logic                    accept;

  // in_ready depends only on registered state and out_ready, never on in_valid
  assign in_ready = !out_valid_q || alu_if.out_ready;
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    out_valid_d   = out_valid_q;
    operand_a_d   = operand_a_q;
    operand_b_d   = operand_b_q;
    alu_control_d = alu_control_q;
    rd_addr_d     = rd_addr_q;
    reg_write_d   = reg_write_q;
    illegal_d     = illegal_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d   = 1'b1;
      operand_a_d   = dec_a;
      operand_b_d   = dec_b;
      alu_control_d = dec_ctrl;
      rd_addr_d     = dec_rd;
      reg_write_d   = dec_rw;
      illegal_d     = dec_ill;
    end else if (alu_if.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q   <= 1'b0;
      operand_a_q   <= '0;
      operand_b_q   <= '0;
      alu_control_q <= '0;
      rd_addr_q     <= '0;
      reg_write_q   <= 1'b0;
      illegal_q     <= 1'b0;
    end else begin
      out_valid_q   <= out_valid_d;
      operand_a_q   <= operand_a_d;
      operand_b_q   <= operand_b_d;
      alu_control_q <= alu_control_d;
      rd_addr_q     <= rd_addr_d;
      reg_write_q   <= reg_write_d;
      illegal_q     <= illegal_d;
    end
  end

  assign alu_if.out_valid   = out_valid_q;
  assign alu_if.operand_a   = operand_a_q;
  assign alu_if.operand_b   = operand_b_q;
  assign alu_if.alu_control = alu_control_q;
  assign alu_if.rd_addr     = rd_addr_q;
  assign alu_if.reg_write   = reg_write_q;
  assign alu_if.illegal     = illegal_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: table of hand-decoded instructions streamed back to back,
// plus sequences for reset, backpressure, flush and reset during a stalled transfer.
module tb_alu_issue;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;

  int errors = 0;
  int checks = 0;

  alu_issue_if #(.DataWidth(32), .RegAddrWidth(5)) alu_if ();

  alu_issue #(.DataWidth(32), .RegAddrWidth(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .instr   (instr),
    .pc      (pc),
    .rs1_data(rs1_data),
    .rs2_data(rs2_data),
    .alu_if  (alu_if.master)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic [3:0]  exp_ctrl;
    logic [4:0]  exp_rd;
    logic        exp_rw;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i, input logic [31:0] p,
                       input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1;
    instr    = i;
    pc       = p;
    rs1_data = a;
    rs2_data = b;
  endtask

  task automatic check_outputs(input string tag, input vec_t v);
    check({tag, ".out_valid"}, {31'b0, alu_if.out_valid}, 32'd1);
    check({tag, ".operand_a"}, alu_if.operand_a, v.exp_a);
    check({tag, ".operand_b"}, alu_if.operand_b, v.exp_b);
    check({tag, ".alu_control"}, {28'b0, alu_if.alu_control}, {28'b0, v.exp_ctrl});
    check({tag, ".illegal"}, {31'b0, alu_if.illegal}, {31'b0, v.exp_ill});
    check({tag, ".reg_write"}, {31'b0, alu_if.reg_write}, {31'b0, v.exp_rw});
    if (!v.exp_ill) check({tag, ".rd_addr"}, {27'b0, alu_if.rd_addr}, {27'b0, v.exp_rd});
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".out_valid"}, {31'b0, alu_if.out_valid}, 32'd0);
    check({tag, ".operand_a"}, alu_if.operand_a, 32'd0);
    check({tag, ".operand_b"}, alu_if.operand_b, 32'd0);
    check({tag, ".alu_control"}, {28'b0, alu_if.alu_control}, 32'd0);
    check({tag, ".rd_addr"}, {27'b0, alu_if.rd_addr}, 32'd0);
    check({tag, ".reg_write"}, {31'b0, alu_if.reg_write}, 32'd0);
    check({tag, ".illegal"}, {31'b0, alu_if.illegal}, 32'd0);
  endtask

  initial begin
    //            instr          pc            rs1           rs2           A             B             ctrl  rd  rw ill
    vecs[0]  = '{32'h402081B3, 32'h0,        32'd10,       32'd3,        32'd10,       32'd3,        4'h1, 5'd3, 1'b1, 1'b0}; // sub x3,x1,x2
    vecs[1]  = '{32'h40435293, 32'h0,        32'h80000000, 32'h0,        32'h80000000, 32'd4,        4'h7, 5'd5, 1'b1, 1'b0}; // srai x5,x6,4
    vecs[2]  = '{32'h123450B7, 32'h0,        32'hDEADBEEF, 32'h0,        32'h0,        32'h12345000, 4'hF, 5'd1, 1'b1, 1'b0}; // lui x1
    vecs[3]  = '{32'hFFF00093, 32'h0,        32'h0,        32'h0,        32'h0,        32'hFFFFFFFF, 4'h0, 5'd1, 1'b1, 1'b0}; // addi x1,x0,-1
    vecs[4]  = '{32'h00000013, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        4'h0, 5'd0, 1'b0, 1'b0}; // nop
    vecs[5]  = '{32'h0000006F, 32'h0,        32'h55,       32'h66,       32'h0,        32'h0,        4'h0, 5'd0, 1'b0, 1'b1}; // jal
    vecs[6]  = '{32'h00001397, 32'h100,      32'h0,        32'h0,        32'h100,      32'h1000,     4'h0, 5'd7, 1'b1, 1'b0}; // auipc x7,1
    vecs[7]  = '{32'h00209233, 32'h0,        32'd1,        32'hFFFFFF23, 32'd1,        32'h3,        4'h2, 5'd4, 1'b1, 1'b0}; // sll x4,x1,x2
    vecs[8]  = '{32'h40209233, 32'h0,        32'd1,        32'd2,        32'h0,        32'h0,        4'h0, 5'd4, 1'b0, 1'b1}; // sll bad funct7
    vecs[9]  = '{32'h40431293, 32'h0,        32'd7,        32'd0,        32'h0,        32'h0,        4'h0, 5'd5, 1'b0, 1'b1}; // slli bad funct7
    vecs[10] = '{32'h00A4B433, 32'h0,        32'h11,       32'h22,       32'h11,       32'h22,       4'h4, 5'd8, 1'b1, 1'b0}; // sltu x8,x9,x10
    vecs[11] = '{32'h0F01F113, 32'h0,        32'hABCD,     32'h0,        32'hABCD,     32'hF0,       4'h9, 5'd2, 1'b1, 1'b0}; // andi x2,x3,0xf0
    vecs[12] = '{32'h00316033, 32'h0,        32'h0F0,      32'h00F,      32'h0F0,      32'h00F,      4'h8, 5'd0, 1'b0, 1'b0}; // or x0,x2,x3
    vecs[13] = '{32'h0062D293, 32'h0,        32'hFF,       32'h0,        32'hFF,       32'd6,        4'h6, 5'd5, 1'b1, 1'b0}; // srli x5,x5,6

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
    instr = '0; pc = '0; rs1_data = '0; rs2_data = '0;
    alu_if.out_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
    check_reset_state("reset");
    check("reset.in_ready", {31'b0, in_ready}, 32'd1);

    // back-to-back stream with out_ready=1: one instruction per cycle
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].instr, vecs[i].pc, vecs[i].rs1, vecs[i].rs2);
      step();
      check_outputs($sformatf("vec%0d", i), vecs[i]);
      check($sformatf("vec%0d.in_ready", i), {31'b0, in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    step();
    check("drain.out_valid", {31'b0, alu_if.out_valid}, 32'd0);

    // backpressure: hold sub, offer lui for 3 cycles
    drive(vecs[0].instr, vecs[0].pc, vecs[0].rs1, vecs[0].rs2);
    step();
    alu_if.out_ready = 1'b0;
    drive(vecs[2].instr, vecs[2].pc, vecs[2].rs1, vecs[2].rs2);
    for (int c = 0; c < 3; c++) begin
      step();
      check_outputs($sformatf("stall%0d", c), vecs[0]);
      check($sformatf("stall%0d.in_ready", c), {31'b0, in_ready}, 32'd0);
    end
    flush = 1'b1;
    step();
    check("flush.out_valid", {31'b0, alu_if.out_valid}, 32'd0);
    check("flush.in_ready", {31'b0, in_ready}, 32'd1);
    flush = 1'b0;
    in_valid = 1'b0;
    step();
    check("post_flush.out_valid", {31'b0, alu_if.out_valid}, 32'd0);

    // flush wins over a simultaneous accept
    alu_if.out_ready = 1'b1;
    drive(vecs[1].instr, vecs[1].pc, vecs[1].rs1, vecs[1].rs2);
    flush = 1'b1;
    step();
    check("flush_accept.out_valid", {31'b0, alu_if.out_valid}, 32'd0);
    flush = 1'b0;
    step();
    check_outputs("after_flush", vecs[1]);

    // reset while a transfer is stalled drops it
    alu_if.out_ready = 1'b0;
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_state("mid_reset");
    check("mid_reset.in_ready", {31'b0, in_ready}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
